// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    // STATUS word layout; the FIFO count field starts at ST_COUNT_LSB
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_COUNT_LSB = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_n;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)
            count_n = count + 1'b1;
        else if (!do_push && do_pop)
            count_n = count - 1'b1;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes, STATUS is
// readable on the load path, and a store into a full queue stalls the core.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_mem_write,
    input  logic [31:0] out_mem_addr,
    input  logic [31:0] mem_mem_wb_data,
    input  logic [31:0] data_mem_addr,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        stop_req,
    output logic        txd,
    output logic        tx_busy
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            BW       = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    tx_state_t     state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          txd_n;

    logic          wr_tx;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic [31:0]   status;
    logic          unused_data_hi;

    assign unused_data_hi = ^mem_mem_wb_data[31:8];

    assign wr_tx    = is_mem_write && (out_mem_addr == BASE_ADDR + TXDATA_OFS);
    // Full is the registered flag, so a same-edge pop never lets a refused store in
    assign stop_req = wr_tx & fifo_full;
    assign push     = wr_tx & ~fifo_full;
    assign tx_busy  = ~fifo_empty | (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (mem_mem_wb_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    baud_n  = BAUD_MAX;
                    state_n = START;
                end
            end
            START: begin
                if (baud == '0) begin
                    baud_n  = BAUD_MAX;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    shift_n = shift >> 1;
                    baud_n  = BAUD_MAX;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            STOP: begin
                if (baud == '0)
                    state_n = IDLE;
                else
                    baud_n = baud - 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the state being entered, so each bit changes on its edge
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
        end
    end

    always_comb begin
        status                          = '0;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_BUSY]                 = (state != IDLE);
        status[ST_COUNT_LSB +: AW+1]    = fifo_count;
    end

    assign rd_hit  = (data_mem_addr == BASE_ADDR + STATUS_OFS);
    assign rd_data = rd_hit ? status : 32'h0;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-store port, downstream of the memory-access stage.
- Consumes core stores (is_mem_write, out_mem_addr, mem_mem_wb_data) to its TXDATA address, buffers bytes in a FIFO and serialises them 8N1, LSB first.
- Supplies a readable STATUS word on the core's load path and raises a stall request into the core's stop input when a store meets a full FIFO.

Parameters:
- CLK_DIV, 868, clocks per bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, byte FIFO depth; power of two, >= 2.
- BASE_ADDR, 32'hF000_0000, word-aligned base; TXDATA = BASE+0, STATUS = BASE+4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- is_mem_write  in  1  core store strobe.
- out_mem_addr  in  32  store address.
- mem_mem_wb_data  in  32  store data; bits [7:0] used.
- data_mem_addr  in  32  core load address.
- rd_hit  out  1  data_mem_addr == BASE+4 (combinational).
- rd_data  out  32  STATUS when rd_hit, else 0 (combinational).
- stop_req  out  1  stall request, ORed into core stop by the top level.
- txd  out  1  serial line, idle high.
- tx_busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - txd = 1, FSM = IDLE, FIFO empty (count 0), baud counter 0, bit index 0.
  - tx_busy = 0, stop_req = 0.
- Push condition: wr_tx = is_mem_write & (out_mem_addr == BASE_ADDR). All other addresses are ignored. Sub-word address bits are not masked; exact match only.
- stop_req = wr_tx & fifo_full, combinational, from the registered full flag.
  - On that cycle the byte is NOT pushed. The core holds the store while stopped and the push retries next cycle.
- Push when not full: byte [7:0] enters the FIFO at the edge; count increments.
- STATUS word:
  - bit0 = full, bit1 = empty, bit2 = FSM != IDLE.
  - bits [3+log2(FIFO_DEPTH):3] = FIFO count; remaining bits 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty at an edge, pop head into shift register, load baud counter with CLK_DIV-1, go START. txd = 1 while in IDLE.
  - START: txd = 0. When baud counter reaches 0, reload it, bit index = 0, go DATA.
  - DATA: txd = shift[0]. On baud counter 0: shift right, reload. After bit index 7 completes go STOP, else increment.
  - STOP: txd = 1. On baud counter 0 go IDLE. A waiting byte is popped on the following edge, so one idle clock of txd = 1 sits between frames.
  - Baud counter decrements every clock outside IDLE.
- txd is registered from the FSM state and shift register (glitch-free).
- Latency and frame timing:
  - Store accepted at edge E (FIFO empty, IDLE): pop at E+1, txd falls at E+1.
  - Each bit lasts exactly CLK_DIV clocks.
  - Full frame = 10*CLK_DIV clocks.
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: push refused (stop_req) even if a pop occurs the same edge; no bypass.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Reset mid-frame: at the reset edge txd = 1, FIFO flushed, FSM IDLE; the partial frame is abandoned.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP).
  - Register offset constants TXDATA_OFS = 0, STATUS_OFS = 4.
  - STATUS bit index constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Inputs: push, pop, din. Outputs: dout, full, empty, count.
  - Synchronous active-high reset; registered flags; reuse-ready for a later UART RX.

Test Plan:
- Single byte: CLK_DIV = 4, store 0x55 to BASE+0 at edge E -> txd low at E+1 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks; tx_busy drops after the stop bit.
- Back-to-back: store 0xA5 and 0x3C on consecutive cycles -> two frames, 1 idle clock between stop bit and second start bit, correct LSB-first bits.
- Full stall: FIFO_DEPTH = 4, CLK_DIV = 4, 6 consecutive stores -> stop_req high on the 6th attempt until a pop frees a slot; all 6 bytes transmitted in order, none lost or duplicated.
- Status read: after 3 pushes during an active frame, read BASE+4 -> rd_hit = 1, rd_data = count 3, bit2 = 1, bit1 = 0, bit0 = 0; read BASE+8 -> rd_hit = 0, rd_data = 0.
- Address filter: store to BASE+4 and to 0x0000_0000 -> no push, FIFO count stays 0, txd stays 1, stop_req stays 0.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> next edge txd = 1, STATUS reads empty, tx_busy = 0; a new store afterwards transmits normally.
